// File: rtl/leaf_out_packetizer_if.sv
// Stream bundle between the user-side output ports and the BFT leaf port.
//   din_user    : concatenated user words, port i at slice i
//   vld_user    : word valid per port
//   ack_user    : word consumed per port (same cycle as the grant)
//   dout_packet : packet toward the BFT, all zero when idle
// master = user/BFT side of the packetizer, slave = the packetizer itself.
interface leaf_out_packetizer_if #(
  parameter int NUM_OUT_PORTS = 4,
  parameter int PAYLOAD_BITS  = 32,
  parameter int PACKET_BITS   = 49
);
  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] din_user;
  logic [NUM_OUT_PORTS-1:0]              vld_user;
  logic [NUM_OUT_PORTS-1:0]              ack_user;
  logic [PACKET_BITS-1:0]                dout_packet;

  modport master (
    output din_user,
    output vld_user,
    input  ack_user,
    input  dout_packet
  );

  modport slave (
    input  din_user,
    input  vld_user,
    output ack_user,
    output dout_packet
  );
endinterface

// File: rtl/leaf_out_packetizer.sv
// Output-side packet builder for a BFT leaf, network clock domain.
// Round-robin arbitration over NUM_OUT_PORTS user streams, per-port credit
// check, destination stamping from a small config table and a per-port
// receiver BRAM write address. One registered packet per cycle; the BFT
// cannot stall, so flow control is credit based only.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   bus (slave)           : din_user / vld_user / ack_user / dout_packet
//   cfg_wr/port/dst_leaf/dst_port : destination table write
//   credit_vld/credit_port: freespace update (+FREESPACE_UPDATE_SIZE)
// Packet: {valid, dst_leaf, dst_port, addr, payload}.
module leaf_out_packetizer #(
  parameter int PACKET_BITS           = 49,
  parameter int PAYLOAD_BITS          = 32,
  parameter int NUM_LEAF_BITS         = 5,
  parameter int NUM_PORT_BITS         = 4,
  parameter int NUM_ADDR_BITS         = 7,
  parameter int NUM_OUT_PORTS         = 4,
  parameter int FREESPACE_UPDATE_SIZE = 64
) (
  input  logic                             clk,
  input  logic                             reset,
  leaf_out_packetizer_if.slave             bus,
  input  logic                             cfg_wr,
  input  logic [$clog2(NUM_OUT_PORTS)-1:0] cfg_port,
  input  logic [NUM_LEAF_BITS-1:0]         cfg_dst_leaf,
  input  logic [NUM_PORT_BITS-1:0]         cfg_dst_port,
  input  logic                             credit_vld,
  input  logic [$clog2(NUM_OUT_PORTS)-1:0] credit_port
);

  localparam int PORT_W     = $clog2(NUM_OUT_PORTS);
  localparam int CREDIT_W   = NUM_ADDR_BITS + 1;
  localparam int CREDIT_MAX = 1 << NUM_ADDR_BITS;

  typedef logic [PORT_W-1:0]        port_idx_t;
  typedef logic [CREDIT_W-1:0]      credit_t;
  typedef logic [NUM_ADDR_BITS-1:0] addr_t;

  typedef struct packed {
    logic [NUM_LEAF_BITS-1:0] leaf;
    logic [NUM_PORT_BITS-1:0] port;
  } dst_t;

  localparam addr_t     ADDR_ONE = addr_t'(1);
  localparam port_idx_t PORT_ONE = port_idx_t'(1);
  localparam port_idx_t PORT_LAST = port_idx_t'(NUM_OUT_PORTS - 1);

  dst_t                     dst_tbl     [NUM_OUT_PORTS];
  logic [NUM_OUT_PORTS-1:0] dst_valid;
  credit_t                  credit      [NUM_OUT_PORTS];
  credit_t                  credit_next [NUM_OUT_PORTS];
  addr_t                    addr_cnt    [NUM_OUT_PORTS];
  port_idx_t                rr_ptr;
  port_idx_t                grant_idx;
  logic                     grant_vld;
  logic [NUM_OUT_PORTS-1:0] eligible;

  always_comb begin
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      eligible[i] = bus.vld_user[i] && dst_valid[i] && (credit[i] != '0);
    end
  end

  // Round-robin search starting at rr_ptr; first eligible port wins.
  always_comb begin : arb
    int idx;
    // NOTE: every always_comb output gets a default before any conditional
    // assignment, otherwise the tool infers a latch to hold the old value.
    grant_vld = 1'b0;
    grant_idx = '0;
    idx       = 0;
    for (int k = 0; k < NUM_OUT_PORTS; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_OUT_PORTS;
      if (!grant_vld && eligible[idx]) begin
        grant_vld = 1'b1;
        grant_idx = port_idx_t'(idx);
      end
    end
  end

  // Ack is combinational with the grant; eligibility already requires vld.
  always_comb begin
    bus.ack_user = '0;
    if (grant_vld) begin
      bus.ack_user[grant_idx] = 1'b1;
    end
  end

  // Credit update and consumption on the same port combine before the
  // saturation, so 128 + 64 - 1 stays at 128 and 10 + 64 - 1 gives 73.
  always_comb begin : credit_calc
    int c;
    c = 0;
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      c = int'(credit[i]);
      if (credit_vld && credit_port == port_idx_t'(i)) begin
        c = c + FREESPACE_UPDATE_SIZE;
      end
      if (grant_vld && grant_idx == port_idx_t'(i)) begin
        c = c - 1;
      end
      if (c > CREDIT_MAX) begin
        c = CREDIT_MAX;
      end
      credit_next[i] = credit_t'(c);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.dout_packet <= '0;
      dst_valid       <= '0;
      rr_ptr          <= '0;
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        credit[i]   <= credit_t'(CREDIT_MAX);
        addr_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        credit[i] <= credit_next[i];
      end
      if (cfg_wr) begin
        dst_valid[cfg_port] <= 1'b1;
      end
      if (grant_vld) begin
        // Table read here sees the pre-write entry, so a same-cycle rewrite
        // only affects later packets.
        bus.dout_packet <= {1'b1,
                            dst_tbl[grant_idx],
                            addr_cnt[grant_idx],
                            bus.din_user[int'(grant_idx)*PAYLOAD_BITS +: PAYLOAD_BITS]};
        addr_cnt[grant_idx] <= addr_cnt[grant_idx] + ADDR_ONE;
        rr_ptr <= (grant_idx == PORT_LAST) ? '0 : grant_idx + PORT_ONE;
      end else begin
        bus.dout_packet <= '0;
      end
    end
  end

  // NOTE: the table contents carry no reset; dst_valid gates every use, so
  // stale entries are never observable and the storage stays a plain RAM.
  always_ff @(posedge clk) begin
    if (cfg_wr) begin
      dst_tbl[cfg_port] <= '{leaf: cfg_dst_leaf, port: cfg_dst_port};
    end
  end

endmodule

// File: tb/tb_leaf_out_packetizer.sv
// Self-checking bench for leaf_out_packetizer. Stimulus pushes expected
// packets into a scoreboard queue; a monitor pops and compares whenever the
// DUT drives a non-zero packet. Inputs change 1 time unit after posedge,
// outputs are sampled on the negedge.
module tb_leaf_out_packetizer;

  logic       clk;
  logic       reset;
  logic       cfg_wr;
  logic [1:0] cfg_port;
  logic [4:0] cfg_dst_leaf;
  logic [3:0] cfg_dst_port;
  logic       credit_vld;
  logic [1:0] credit_port;

  leaf_out_packetizer_if #(.NUM_OUT_PORTS(4), .PAYLOAD_BITS(32), .PACKET_BITS(49)) bus ();

  leaf_out_packetizer dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .cfg_wr       (cfg_wr),
    .cfg_port     (cfg_port),
    .cfg_dst_leaf (cfg_dst_leaf),
    .cfg_dst_port (cfg_dst_port),
    .credit_vld   (credit_vld),
    .credit_port  (credit_port)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [48:0] sb [$];

  // Bench-side view of the destination table and expected next address.
  logic [4:0] leaf_tbl  [4];
  logic [3:0] dport_tbl [4];
  logic [6:0] exp_addr  [4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [48:0] make_pkt(input logic [4:0] leaf, input logic [3:0] dp,
                                           input logic [6:0] addr, input logic [31:0] pl);
    return {1'b1, leaf, dp, addr, pl};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    bus.vld_user = '0;
    cfg_wr       = 1'b0;
    credit_vld   = 1'b0;
    cyc();
    @(negedge clk);
    check("reset_dout", bus.dout_packet, 0);
    check("reset_ack", bus.ack_user, 0);
    cyc();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) exp_addr[i] = '0;
  endtask

  task automatic cfg(input int p, input int leaf, input int dp);
    cfg_wr       = 1'b1;
    cfg_port     = 2'(p);
    cfg_dst_leaf = 5'(leaf);
    cfg_dst_port = 4'(dp);
    cyc();
    cfg_wr = 1'b0;
    leaf_tbl[p]  = 5'(leaf);
    dport_tbl[p] = 4'(dp);
  endtask

  // Hold vld on port p for ncyc cycles; the first nexp cycles must be acked.
  // With upd set, a credit update on port p coincides with the first cycle.
  task automatic run_port(input int p, input int ncyc, input int nexp, input bit upd);
    logic [31:0] pl;
    logic [3:0]  oh;
    oh = 4'b0001 << p;
    for (int k = 0; k < ncyc; k++) begin
      pl = {8'hA5, 8'(p), 16'(k)};
      bus.din_user[p*32 +: 32] = pl;
      bus.vld_user  = oh;
      credit_vld    = upd && (k == 0);
      credit_port   = 2'(p);
      @(negedge clk);
      if (k < nexp) begin
        check("ack_grant", bus.ack_user, oh);
        sb.push_back(make_pkt(leaf_tbl[p], dport_tbl[p], exp_addr[p], pl));
        exp_addr[p]++;
      end else begin
        check("ack_no_credit", bus.ack_user, 0);
      end
      cyc();
    end
    credit_vld   = 1'b0;
    bus.vld_user = '0;
  endtask

  // All four ports valid for n cycles starting from pointer 0.
  task automatic run_all(input int n);
    logic [31:0] pl [4];
    int g;
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < 4; i++) begin
        pl[i] = {8'hC0, 8'(i), 16'(k)};
        bus.din_user[i*32 +: 32] = pl[i];
      end
      bus.vld_user = 4'hF;
      g = k % 4;
      @(negedge clk);
      check("rr_ack", bus.ack_user, 4'b0001 << g);
      sb.push_back(make_pkt(leaf_tbl[g], dport_tbl[g], exp_addr[g], pl[g]));
      exp_addr[g]++;
      cyc();
    end
  endtask

  // Monitor: every non-zero packet must match the head of the scoreboard.
  initial begin
    logic [48:0] exp;
    forever begin
      @(negedge clk);
      if (bus.dout_packet != '0) begin
        if (sb.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_packet: got %h, expected idle zero (t=%0t)",
                   bus.dout_packet, $time);
        end else begin
          exp = sb.pop_front();
          check("packet", bus.dout_packet, exp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bus.din_user = '0;
    bus.vld_user = '0;
    cfg_port     = '0;
    cfg_dst_leaf = '0;
    cfg_dst_port = '0;
    credit_port  = '0;
    do_reset();

    // Basic path: port0 -> leaf 3, port 2; two words, addr 0 then 1.
    cfg(0, 3, 2);
    bus.din_user[31:0] = 32'hDEADBEEF;
    bus.vld_user = 4'b0001;
    @(negedge clk);
    check("basic_ack0", bus.ack_user, 4'b0001);
    sb.push_back(49'h1_1900_DEAD_BEEF);
    cyc();
    bus.din_user[31:0] = 32'h12345678;
    @(negedge clk);
    check("basic_ack1", bus.ack_user, 4'b0001);
    sb.push_back(49'h1_1901_1234_5678);
    cyc();
    bus.vld_user = '0;
    cyc();
    cyc();

    // Round-robin: all ports valid for 8 cycles, order 0,1,2,3,0,1,2,3.
    do_reset();
    cfg(0, 3, 2);
    cfg(1, 5, 1);
    cfg(2, 7, 4);
    cfg(3, 9, 8);
    run_all(8);
    bus.vld_user = '0;
    cyc();

    // Credit exhaustion on port1: 128 words, then stall; +64 credits.
    do_reset();
    cfg(1, 5, 1);
    run_port(1, 130, 128, 1'b0);
    credit_vld  = 1'b1;
    credit_port = 2'd1;
    @(negedge clk);
    check("update_only_ack", bus.ack_user, 0);
    cyc();
    credit_vld = 1'b0;
    run_port(1, 66, 64, 1'b0);

    // Simultaneous update and send: at 128 saturates, at 10 gives 73.
    do_reset();
    cfg(2, 7, 4);
    run_port(2, 1, 1, 1'b1);
    run_port(2, 118, 118, 1'b0);
    run_port(2, 1, 1, 1'b1);
    run_port(2, 75, 73, 1'b0);

    // Unconfigured port: no ack, idle output; config at t -> ack at t+1.
    do_reset();
    bus.din_user[95:64] = 32'h0BAD_F00D;
    bus.vld_user = 4'b0100;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("uncfg_ack", bus.ack_user, 0);
      check("uncfg_dout", bus.dout_packet, 0);
      cyc();
    end
    cfg_wr       = 1'b1;
    cfg_port     = 2'd2;
    cfg_dst_leaf = 5'd7;
    cfg_dst_port = 4'd4;
    @(negedge clk);
    check("cfg_cycle_ack", bus.ack_user, 0);
    cyc();
    cfg_wr = 1'b0;
    leaf_tbl[2]  = 5'd7;
    dport_tbl[2] = 4'd4;
    run_port(2, 2, 2, 1'b0);

    // Rewrite while sending: this word keeps the old entry, addr continues.
    cfg_wr       = 1'b1;
    cfg_port     = 2'd2;
    cfg_dst_leaf = 5'd11;
    cfg_dst_port = 4'd6;
    bus.din_user[95:64] = 32'h5555_AAAA;
    bus.vld_user = 4'b0100;
    @(negedge clk);
    check("rewrite_ack", bus.ack_user, 4'b0100);
    sb.push_back(49'h1_3A02_5555_AAAA);
    exp_addr[2]++;
    cyc();
    cfg_wr = 1'b0;
    leaf_tbl[2]  = 5'd11;
    dport_tbl[2] = 4'd6;
    run_port(2, 1, 1, 1'b0);

    // Reset mid-stream: grant in the reset cycle is dropped.
    do_reset();
    cfg(0, 3, 2);
    cfg(1, 5, 1);
    cfg(2, 7, 4);
    cfg(3, 9, 8);
    run_all(3);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) exp_addr[i] = '0;
    @(negedge clk);
    check("midreset_ack", bus.ack_user, 0);
    check("midreset_dout", bus.dout_packet, 0);
    cyc();
    bus.vld_user = '0;
    cfg(3, 9, 8);
    run_port(3, 1, 1, 1'b0);
    run_port(3, 129, 127, 1'b0);

    repeat (3) cyc();
    check("scoreboard_drained", 64'(sb.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/leaf_out_packetizer.md
Name: leaf_out_packetizer

Overview:
Output-side packet builder between the user-side output streams and the BFT leaf port, running in the 400 MHz network clock domain.
- Takes NUM_OUT_PORTS 32-bit vld/ack streams.
- Arbitrates between them round-robin, checks per-port credits, and stamps each word with a configured destination (leaf, port) and a per-port BRAM write address.
- Drives one 49-bit packet per cycle toward the BFT. The BFT cannot stall, so flow control is purely credit-based.

Parameters:
PACKET_BITS, 49, packet width; equals 1+NUM_LEAF_BITS+NUM_PORT_BITS+NUM_ADDR_BITS+PAYLOAD_BITS
PAYLOAD_BITS, 32, data word width
NUM_LEAF_BITS, 5, destination leaf id width
NUM_PORT_BITS, 4, destination port id width
NUM_ADDR_BITS, 7, receiver BRAM address width
NUM_OUT_PORTS, 4, number of user output streams
FREESPACE_UPDATE_SIZE, 64, credits returned per freespace update

Ports:
clk  in  1  network clock (clk_400)
reset  in  1  synchronous active-high reset
din_user  in  NUM_OUT_PORTS*PAYLOAD_BITS  concatenated user words; port i at slice i
vld_user  in  NUM_OUT_PORTS  word valid per port
ack_user  out  NUM_OUT_PORTS  word consumed per port
cfg_wr  in  1  destination-table write strobe
cfg_port  in  log2(NUM_OUT_PORTS)  table entry to write
cfg_dst_leaf  in  NUM_LEAF_BITS  destination leaf
cfg_dst_port  in  NUM_PORT_BITS  destination port
credit_vld  in  1  freespace update strobe
credit_port  in  log2(NUM_OUT_PORTS)  port receiving credits
dout_packet  out  PACKET_BITS  packet to BFT; all zero when idle

Behaviour:
Packet format, MSB to LSB:
- [48] valid
- [47:43] dst leaf
- [42:39] dst port
- [38:32] addr
- [31:0] payload

Reset state:
- dout_packet = 0 and ack_user = 0.
- All table entries are invalid.
- Every credit counter is 2^NUM_ADDR_BITS (128).
- Every address counter is 0.
- The round-robin pointer is 0.

Eligibility: port i is eligible when all three hold:
- vld_user[i] = 1
- its table entry is valid
- credit[i] > 0

Arbitration:
- Search starts at the pointer and wraps modulo NUM_OUT_PORTS. The first eligible port wins.
- At most one grant per cycle.
- After a grant to port g, the pointer becomes (g+1) mod NUM_OUT_PORTS. With no grant, the pointer holds.

Handshake:
- ack_user[g] is combinational and asserted in the same cycle as the grant. Transfer occurs when vld & ack are both 1.
- ack_user is never asserted for a port whose vld is low.

Latency:
- dout_packet is registered. The granted word appears on the next cycle with valid = 1, the destination from the table, and addr = addr_cnt[g].
- A cycle with no grant outputs all zeros.
- Throughput is 1 packet per cycle.

Per-port counters:
- addr_cnt[g] increments modulo 2^NUM_ADDR_BITS on each transfer (127 wraps to 0).
- credit[g] decrements by 1 on each transfer.

Credit update:
- credit_vld adds FREESPACE_UPDATE_SIZE to credit[credit_port], saturating at 128.
- Update and transfer on the same port in the same cycle: new value = min(credit + 64 - 1, 128).

Config:
- cfg_wr writes the entry and marks it valid from the next cycle.
- A transfer in the same cycle as a write to the same entry uses the old entry.
- A rewrite does not reset addr_cnt or credit.
- A port with an invalid entry is never granted, and its words are held upstream.

Reset mid-operation: reset has priority over every strobe. The packet in flight is dropped (dout_packet = 0 on the next cycle).

Test Plan:
- Basic path: reset; cfg port0 -> leaf 3, port 2; vld_user[0] = 1, payload 0xDEADBEEF -> ack_user[0] in the same cycle; next cycle dout_packet = {1, 5'd3, 4'd2, 7'd0, 0xDEADBEEF}, then addr 1 on the next word.
- Round-robin fairness: configure all 4 ports, hold all vld high for 8 cycles -> grant order 0,1,2,3,0,1,2,3 with no idle cycles.
- Credit exhaustion: send 128 words on port1 with no updates -> ack stops after the 128th word (addr wraps 127 -> 0 on word 128); one credit_vld on port1 -> exactly 64 more words accepted.
- Simultaneous update and send at credit = 128 -> credit saturates at 128; at credit = 10 -> credit becomes 73.
- Unconfigured port: vld_user[2] = 1 with no cfg -> ack_user[2] stays 0 and dout_packet stays 0; cfg written at cycle t -> first ack at t+1.
- Reset mid-stream: assert reset during continuous traffic -> dout_packet = 0 and ack_user = 0 the next cycle; credits return to 128, addr to 0, table invalid.
